// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle ALU with a valid/ready handshake on both sides.
//
// Logic and shift operations finish in a single cycle. MUL (unsigned shift-add)
// and DIVU (unsigned restoring) each run one iteration per cycle for WIDTH
// cycles. The result is held in DONE until the consumer accepts it.
//
// Ports
//   clk        : clock; all state is updated on the rising edge
//   rst_n      : asynchronous reset, active low
//   in_valid   : an operation request is present on X, Y, S
//   in_ready   : high in IDLE; the block can accept an operation
//   X, Y       : operands (WIDTH bits)
//   S          : operation select (4 bits)
//   out_valid  : high in DONE; r, r_hi and the flags hold a result
//   out_ready  : the consumer accepts the result
//   r          : primary result
//   r_hi       : MUL high half or DIVU remainder, 0 for every other operation
//   Zflag      : r == 0
//   Vflag      : signed overflow on ADD or SUB
//   Eflag      : divide by zero or unknown S code
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready = 1
// BUSY  | MUL/DIVU iteration, one per cycle while cnt_q counts down to 0
// DONE  | result held on the outputs until out_ready

module alu_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             Zflag,
    output logic             Vflag,
    output logic             Eflag
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             z_q, z_d;
    logic             v_q, v_d;
    logic             e_q, e_d;

    // Single-cycle operation results, taken straight from the inputs at accept.
    logic [WIDTH-1:0] add_res, sub_res, op_res;
    logic             op_v, op_e, op_multi, slt;

    always_comb begin
        add_res  = X + Y;
        sub_res  = X - Y;
        slt      = $signed(X) < $signed(Y);
        op_res   = '0;
        op_v     = 1'b0;
        op_e     = 1'b0;
        op_multi = 1'b0;
        case (S)
            4'd0:  op_res = X & Y;
            4'd1:  op_res = X | Y;
            4'd2: begin
                op_res = add_res;
                op_v   = (X[WIDTH-1] == Y[WIDTH-1]) && (add_res[WIDTH-1] != X[WIDTH-1]);
            end
            4'd6: begin
                op_res = sub_res;
                op_v   = (X[WIDTH-1] != Y[WIDTH-1]) && (sub_res[WIDTH-1] != X[WIDTH-1]);
            end
            4'd7:  op_res = {{(WIDTH-1){1'b0}}, slt};
            4'd8:  op_res = X << Y[CW-1:0];
            4'd9:  op_res = X >> Y[CW-1:0];
            4'd12: op_res = ~(X | Y);
            4'd3, 4'd4: op_multi = 1'b1;
            default: op_e = 1'b1;
        endcase
    end

    // One MUL or DIVU iteration on the {hi_q, lo_q} working pair.
    // MUL: lo_q holds the multiplier, shifted out LSB first while partial sums
    //      of y_q accumulate into hi_q.
    // DIVU: lo_q holds the dividend, shifted into the remainder in hi_q while
    //      quotient bits enter lo_q from the right. With y_q == 0 every trial
    //      subtract succeeds, which naturally yields all-ones and r_hi = X.
    logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
    logic             rem_ge;
    logic [WIDTH-1:0] it_hi, it_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, y_q} : '0);
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, y_q};
        rem_sub = rem_sh - {1'b0, y_q};
        if (div_q) begin
            it_hi = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], rem_ge};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        z_d     = z_q;
        v_d     = v_q;
        e_d     = e_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op_multi) begin
                        state_d = BUSY;
                        cnt_d   = CW'(WIDTH - 1);
                        div_d   = (S == 4'd4);
                        y_d     = Y;
                        hi_d    = '0;
                        lo_d    = X;
                    end else begin
                        state_d = DONE;
                        hi_d    = '0;
                        lo_d    = op_res;
                        z_d     = (op_res == '0);
                        v_d     = op_v;
                        e_d     = op_e;
                    end
                end
            end
            BUSY: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    z_d     = (it_lo == '0);
                    v_d     = 1'b0;
                    e_d     = div_q && (y_q == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            z_q     <= z_d;
            v_q     <= v_d;
            e_q     <= e_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign r         = lo_q;
    assign r_hi      = hi_q;
    assign Zflag     = z_q;
    assign Vflag     = v_q;
    assign Eflag     = e_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
module tb_alu_multiciclo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic [3:0]   S = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] r, r_hi;
    logic         Zflag, Vflag, Eflag;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .S(S),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .r_hi(r_hi),
        .Zflag(Zflag), .Vflag(Vflag), .Eflag(Eflag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic         z;
        logic         v;
        logic         e;
    } res_t;

    res_t sb[$];
    int   lat_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic res_t cur();
        return {r, r_hi, Zflag, Vflag, Eflag};
    endfunction

    function automatic res_t golden(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] s);
        res_t g;
        logic [2*W-1:0] p;
        longint sa;
        g = '0;
        case (s)
            4'd0: g.r = x & y;
            4'd1: g.r = x | y;
            4'd2: begin
                g.r = x + y;
                sa  = longint'($signed(x)) + longint'($signed(y));
                g.v = (sa != longint'($signed(g.r)));
            end
            4'd6: begin
                g.r = x - y;
                sa  = longint'($signed(x)) - longint'($signed(y));
                g.v = (sa != longint'($signed(g.r)));
            end
            4'd7:  g.r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd8:  g.r = x << y[4:0];
            4'd9:  g.r = x >> y[4:0];
            4'd12: g.r = ~(x | y);
            4'd3: begin
                p    = 64'(x) * 64'(y);
                g.r  = p[W-1:0];
                g.rh = p[2*W-1:W];
            end
            4'd4: begin
                if (y == 0) begin
                    g.r  = '1;
                    g.rh = x;
                    g.e  = 1'b1;
                end else begin
                    g.r  = x / y;
                    g.rh = x % y;
                end
            end
            default: g.e = 1'b1;
        endcase
        g.z = (g.r == 0);
        return g;
    endfunction

    function automatic int lat_of(input logic [3:0] s);
        return (s == 4'd3 || s == 4'd4) ? W + 1 : 1;
    endfunction

    // Drives one request and returns #1 after the accept edge. Operands are
    // scrambled afterwards so any late use of X/Y/S would corrupt the result.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] s,
                         input res_t ex, input bit push);
        X = x; Y = y; S = s; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready s=%0d in_ready=%b expected 1", s, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        X = $urandom; Y = $urandom; S = 4'($urandom_range(0, 15));
        if (push) begin
            sb.push_back(ex);
            lat_q.push_back(lat_of(s));
        end
    endtask

    // Waits (bounded) for out_valid and pops the matching expectation.
    task automatic wait_result(output res_t got, output res_t ex, output int lat, output int elat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        got = cur();
        if (sb.size() > 0) begin
            ex   = sb.pop_front();
            elat = lat_q.pop_front();
        end else begin
            ex   = '0;
            elat = -1;
        end
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (cur() !== res_t'(0)) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected 0", cur());
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        res_t got, ex;
        int lat, elat;
        issue(32'h7FFFFFFF, 32'd1, 4'd2, res_t'({32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0}), 1'b1);
        wait_result(got, ex, lat, elat);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL add_ovf_latency got=%0d expected %0d", lat, elat);
        end
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL add_ovf got r=%h rh=%h zve=%b%b%b expected r=%h rh=%h zve=%b%b%b",
                     got.r, got.rh, got.z, got.v, got.e, ex.r, ex.rh, ex.z, ex.v, ex.e);
        end
        transfer();
    endtask

    task automatic test_sub_backpressure();
        res_t got, ex;
        int lat, elat;
        bit bad;
        issue(32'd5, 32'd5, 4'd6, res_t'({32'h0, 32'h0, 1'b1, 1'b0, 1'b0}), 1'b1);
        wait_result(got, ex, lat, elat);
        checks++;
        if (got !== ex || lat !== elat) begin
            failures++;
            $display("FAIL sub_zero got r=%h z=%b lat=%0d expected r=%h z=%b lat=%0d",
                     got.r, got.z, lat, ex.r, ex.z, elat);
        end
        // A competing request while DONE must be ignored.
        bad = 1'b0;
        X = 32'd1; Y = 32'd1; S = 4'd2; in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (cur() !== ex || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL sub_hold got r=%h z=%b ov=%b ir=%b expected r=0 z=1 ov=1 ir=0",
                     r, Zflag, out_valid, in_ready);
        end
        transfer();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sub_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_mul();
        res_t got, ex;
        int lat, elat;
        logic [W-1:0] x, y;
        issue(32'hFFFFFFFF, 32'd2, 4'd3, res_t'({32'hFFFFFFFE, 32'h1, 1'b0, 1'b0, 1'b0}), 1'b1);
        wait_result(got, ex, lat, elat);
        checks++;
        if (lat !== elat) begin
            failures++;
            $display("FAIL mul_latency got=%0d expected %0d", lat, elat);
        end
        checks++;
        if (got !== ex) begin
            failures++;
            $display("FAIL mul_const got r=%h rh=%h expected r=%h rh=%h", got.r, got.rh, ex.r, ex.rh);
        end
        transfer();
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom;
            issue(x, y, 4'd3, golden(x, y, 4'd3), 1'b1);
            wait_result(got, ex, lat, elat);
            checks++;
            if (got !== ex || lat !== elat) begin
                failures++;
                $display("FAIL mul_rand x=%h y=%h got r=%h rh=%h lat=%0d expected r=%h rh=%h lat=%0d",
                         x, y, got.r, got.rh, lat, ex.r, ex.rh, elat);
            end
            transfer();
        end
    endtask

    task automatic test_divu();
        res_t got, ex;
        int lat, elat;
        logic [W-1:0] x, y;
        issue(32'd100, 32'd7, 4'd4, res_t'({32'd14, 32'd2, 1'b0, 1'b0, 1'b0}), 1'b1);
        wait_result(got, ex, lat, elat);
        checks++;
        if (got !== ex || lat !== elat) begin
            failures++;
            $display("FAIL divu_100_7 got r=%h rh=%h e=%b lat=%0d expected r=%h rh=%h e=%b lat=%0d",
                     got.r, got.rh, got.e, lat, ex.r, ex.rh, ex.e, elat);
        end
        transfer();
        issue(32'd9, 32'd0, 4'd4, res_t'({32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b1}), 1'b1);
        wait_result(got, ex, lat, elat);
        checks++;
        if (got !== ex || lat !== elat) begin
            failures++;
            $display("FAIL divu_by_zero got r=%h rh=%h e=%b lat=%0d expected r=%h rh=%h e=%b lat=%0d",
                     got.r, got.rh, got.e, lat, ex.r, ex.rh, ex.e, elat);
        end
        transfer();
        for (int i = 0; i < 3; i++) begin
            x = $urandom; y = $urandom >> $urandom_range(0, 28);
            issue(x, y, 4'd4, golden(x, y, 4'd4), 1'b1);
            wait_result(got, ex, lat, elat);
            checks++;
            if (got !== ex || lat !== elat) begin
                failures++;
                $display("FAIL divu_rand x=%h y=%h got r=%h rh=%h e=%b expected r=%h rh=%h e=%b",
                         x, y, got.r, got.rh, got.e, ex.r, ex.rh, ex.e);
            end
            transfer();
        end
    endtask

    task automatic test_single_ops();
        res_t got, ex;
        int lat, elat;
        logic [W-1:0] x, y;
        logic [3:0] ops [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12};
        issue(32'hFFFFFFFF, 32'd0, 4'd7, res_t'({32'd1, 32'd0, 1'b0, 1'b0, 1'b0}), 1'b1);
        issue_check("slt_neg");
        issue(32'h80000000, 32'h3F, 4'd9, res_t'({32'd1, 32'd0, 1'b0, 1'b0, 1'b0}), 1'b1);
        issue_check("srl_mask");
        issue(32'h1234, 32'h5678, 4'd5, res_t'({32'd0, 32'd0, 1'b1, 1'b0, 1'b1}), 1'b1);
        issue_check("illegal_s5");
        for (int i = 0; i < 16; i++) begin
            x = $urandom; y = $urandom;
            issue(x, y, ops[i % 8], golden(x, y, ops[i % 8]), 1'b1);
            wait_result(got, ex, lat, elat);
            checks++;
            if (got !== ex || lat !== elat) begin
                failures++;
                $display("FAIL single_s%0d x=%h y=%h got r=%h zve=%b%b%b lat=%0d expected r=%h zve=%b%b%b lat=%0d",
                         ops[i % 8], x, y, got.r, got.z, got.v, got.e, lat, ex.r, ex.z, ex.v, ex.e, elat);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            transfer();
        end
    endtask

    // Result check for the constant single-cycle vectors above.
    task automatic issue_check(input string name);
        res_t got, ex;
        int lat, elat;
        wait_result(got, ex, lat, elat);
        checks++;
        if (got !== ex || lat !== elat) begin
            failures++;
            $display("FAIL %s got r=%h rh=%h zve=%b%b%b lat=%0d expected r=%h rh=%h zve=%b%b%b lat=%0d",
                     name, got.r, got.rh, got.z, got.v, got.e, lat, ex.r, ex.rh, ex.z, ex.v, ex.e, elat);
        end
        transfer();
    endtask

    task automatic test_back_to_back();
        issue(32'd1, 32'd2, 4'd2, res_t'({32'd3, 32'd0, 1'b0, 1'b0, 1'b0}), 1'b1);
        issue_check("b2b_first");
        issue(32'd4, 32'd5, 4'd2, res_t'({32'd9, 32'd0, 1'b0, 1'b0, 1'b0}), 1'b0);
        // Present the next request during the transfer cycle: it must wait one edge.
        X = 32'd10; Y = 32'd20; S = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_no_same_cycle out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || r !== 32'd30) begin
            failures++;
            $display("FAIL b2b_second out_valid=%b r=%h expected 1/0000001e", out_valid, r);
        end
        transfer();
    endtask

    task automatic test_reset_abort();
        bit seen;
        issue(32'hDEADBEEF, 32'h12345678, 4'd3, '0, 1'b0);
        seen = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cur() !== res_t'(0) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset_values got=%h ir=%b ov=%b expected 0 1 0", cur(), in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_result out_valid seen=%b expected 0", seen);
        end
        issue(32'd2, 32'd3, 4'd2, res_t'({32'd5, 32'd0, 1'b0, 1'b0, 1'b0}), 1'b1);
        issue_check("abort_then_add");
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_backpressure();
        test_mul();
        test_divu();
        test_single_ops();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_multiciclo.md
ALU_MULTICICLO -- requirements
Module: alu_multiciclo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The block SHALL have ports X and Y, input, WIDTH bits each: the operands.
REQ-007 The block SHALL have port S, input, 4 bits: the operation select.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have port r, output, WIDTH bits: the primary result.
REQ-011 The block SHALL have port r_hi, output, WIDTH bits: the MUL high half or DIVU remainder, and 0 for all other operations.
REQ-012 The block SHALL have ports Zflag, Vflag and Eflag, output, 1 bit each: zero, signed overflow and error flags.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, BUSY and DONE, with in_ready equal to (state==IDLE) and out_valid equal to (state==DONE).
REQ-014 An operation SHALL be accepted on a rising edge with in_valid and in_ready both high; X, Y and S are captured then and ignored afterwards until the next accept.
REQ-015 Single-cycle operations SHALL be S=0 AND, 1 OR, 2 ADD, 6 SUB (X-Y), 7 SLT (signed; r=1 if X<Y else 0), 8 SLL (X<<Y[log2 WIDTH-1:0]), 9 SRL (logical, same shift amount) and 12 NOR; on accept IDLE->DONE, so out_valid rises one cycle after the accept edge.
REQ-016 Multi-cycle operations SHALL be S=3 MUL (unsigned shift-add; {r_hi,r} = full 2*WIDTH product) and S=4 DIVU (unsigned restoring; r=quotient, r_hi=remainder); on accept IDLE->BUSY.
REQ-017 In BUSY, the block SHALL process exactly one iteration per cycle, driven by a counter loaded with WIDTH-1 that decrements each cycle; after the iteration at count 0 it transitions BUSY->DONE, so out_valid rises WIDTH+1 cycles after the accept edge.
REQ-018 In DONE, the block SHALL hold r, r_hi and all flags stable while out_ready is low; DONE->IDLE occurs on the edge where out_ready is high.
REQ-019 A new operation SHALL NOT be accepted in the same cycle as the result transfer; the minimum issue interval is 2 cycles for single-cycle operations.
REQ-020 Zflag SHALL be 1 iff r==0 for the current result, evaluated on the final registered r.
REQ-021 Vflag SHALL be 1 only for ADD or SUB with signed two's-complement overflow, and 0 for all other operations.
REQ-022 For DIVU with Y==0, the block SHALL follow the normal WIDTH+1 latency and produce r=all ones, r_hi=X, Eflag=1.
REQ-023 For an unlisted S code, the block SHALL go IDLE->DONE with r=0, r_hi=0, Zflag=1, Vflag=0, Eflag=1.
REQ-024 Eflag SHALL be 0 in all cases other than REQ-022 and REQ-023.
REQ-025 ADD, SUB, SLL and SRL results SHALL be truncated to WIDTH bits (wrap-around).
REQ-026 Shift amounts SHALL use only the low log2(WIDTH) bits of Y (rounded up).
REQ-027 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.

Reset
REQ-028 While rst_n is low, state SHALL be IDLE, the counter 0, r=0, r_hi=0, Zflag=0, Vflag=0 and Eflag=0; hence in_ready=1 and out_valid=0.
REQ-029 An rst_n assertion in BUSY or DONE SHALL abort the operation immediately with no result delivered; after release the block accepts on the first edge where in_valid is high.

Verification (WIDTH=32)
REQ-030 The bench SHALL apply ADD X=0x7FFFFFFF, Y=1 -> one cycle later out_valid=1, r=0x80000000, Vflag=1, Zflag=0.
REQ-031 The bench SHALL apply SUB X=5, Y=5 with out_ready held low for 3 cycles -> r=0 and Zflag=1 held stable; in_ready stays 0 until the cycle after out_ready rises.
REQ-032 The bench SHALL apply MUL X=0xFFFFFFFF, Y=2 -> out_valid exactly 33 cycles after accept, r=0xFFFFFFFE, r_hi=1.
REQ-033 The bench SHALL apply DIVU X=100, Y=7 -> r=14, r_hi=2, Eflag=0; then DIVU X=9, Y=0 -> r=0xFFFFFFFF, r_hi=9, Eflag=1.
REQ-034 The bench SHALL apply SLT X=0xFFFFFFFF (-1), Y=0 -> r=1; SRL X=0x80000000, Y=0x3F -> r=1; S=5 -> r=0, Eflag=1, Zflag=1.
REQ-035 The bench SHALL assert rst_n low 10 cycles into a MUL -> out_valid is never asserted, all outputs return to reset values, and a following ADD 2+3 yields r=5.
